// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO-side arbiters: FSM state encoding and
// the sizing rule for burst beat counters.
package fifo_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // One extra bit so the counter can also hold the value BURST itself.
  function automatic int beat_cnt_width(input int burst);
    return $clog2(burst) + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request bit scanning
// upward from last_gnt+1 with wrap-around. Shared by write and read schedulers.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_gnt,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest candidate wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int off = N; off >= 1; off--) begin
      cand = IW'((int'(last_gnt) + off) % N);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional per-requester beat counters are enabled with FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  parameter int BURST   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       wr_en,
  output logic [WIDTH-1:0]           wr_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_active
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic                       stat_clr,
  output logic [NUM_REQ*16-1:0]      stat_beats
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = beat_cnt_width(BURST);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [IW-1:0] last_gnt_q, last_gnt_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          sel_valid;
  logic [WIDTH-1:0] sel_data;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req      (req_valid),
    .last_gnt (last_gnt_q),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  always_comb begin
    sel_valid    = req_valid[grant_id_q];
    sel_data     = req_data[int'(grant_id_q)*WIDTH +: WIDTH];
    grant_active = (state_q == ARB_GRANT);
    req_ready    = '0;
    wr_en        = 1'b0;
    wr_data      = '0;
    if (grant_active) begin
      req_ready[grant_id_q] = ~fifo_full;
      wr_en                 = sel_valid & ~fifo_full;
      if (wr_en) wr_data = sel_data;
    end
  end

  assign grant_id = grant_id_q;

  // A full stall holds everything; only a beat or a dropped valid can end a grant.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_gnt_d = last_gnt_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d    = ARB_GRANT;
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
        end
      end
      ARB_GRANT: begin
        if (!sel_valid) begin
          state_d    = ARB_IDLE;
          last_gnt_d = grant_id_q;
        end else if (wr_en) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == BW'(BURST - 1)) begin
            state_d    = ARB_IDLE;
            last_gnt_d = grant_id_q;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      grant_id_q <= '0;
      last_gnt_q <= IW'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_gnt_q <= last_gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] stat_q, stat_d;

  // Clear has priority over a coincident beat; counters saturate.
  always_comb begin
    stat_d = stat_q;
    if (stat_clr) begin
      stat_d = '0;
    end else if (wr_en && (stat_q[grant_id_q] != 16'hFFFF)) begin
      stat_d[grant_id_q] = stat_q[grant_id_q] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign stat_beats = stat_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized
// producers, all compared each cycle against a behavioural arbitration model.
module tb_fifo_wr_arbiter;

  localparam int WIDTH   = 16;
  localparam int NUM_REQ = 4;
  localparam int BURST   = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     wr_en;
  logic [WIDTH-1:0]         wr_data;
  logic [1:0]               grant_id;
  logic                     grant_active;
`ifdef FIFO_WR_ARB_STATS_EN
  logic                     stat_clr;
  logic [NUM_REQ*16-1:0]    stat_beats;
`endif

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .BURST(BURST)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .grant_id     (grant_id),
    .grant_active (grant_active)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_beats   (stat_beats)
`endif
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;

  // Model: owner is -1 when no grant is held.
  int mOwner, mBeats, mLast, mGid;
  int mStat[NUM_REQ];

  int idx[NUM_REQ];
  int rem[NUM_REQ];
  logic [NUM_REQ-1:0] accMask;
  int wdataQ[$];
  int wcycQ[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] wordOf(input int r);
    return 16'((r + 1) * 4096 + idx[r]);
  endfunction

  // Compare process: check outputs against the model, then advance the model.
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] er;
    logic               ew;
    logic [15:0]        ed;
    logic [63:0]        es;
    if (!rst_n) begin
      mOwner = -1; mBeats = 0; mLast = NUM_REQ - 1; mGid = 0;
      for (int r = 0; r < NUM_REQ; r++) mStat[r] = 0;
      accMask = '0;
      checkOutput("rst_wr_en", 64'(wr_en), 64'd0);
      checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
      checkOutput("rst_grant_active", 64'(grant_active), 64'd0);
      checkOutput("rst_wr_data", 64'(wr_data), 64'd0);
    end else begin
      er = '0; ew = 1'b0; ed = '0;
      if (mOwner >= 0) begin
        if (!fifo_full) er[mOwner] = 1'b1;
        ew = req_valid[mOwner] && !fifo_full;
        if (ew) ed = wordOf(mOwner);
      end
      checkOutput("wr_en", 64'(wr_en), 64'(ew));
      checkOutput("wr_data", 64'(wr_data), 64'(ed));
      checkOutput("req_ready", 64'(req_ready), 64'(er));
      checkOutput("grant_active", 64'(grant_active), 64'(mOwner >= 0));
      checkOutput("grant_id", 64'(grant_id), 64'(mGid));
`ifdef FIFO_WR_ARB_STATS_EN
      es = '0;
      for (int r = 0; r < NUM_REQ; r++) es[r*16 +: 16] = 16'(mStat[r]);
      checkOutput("stat_beats", stat_beats, es);
      if (stat_clr) begin
        for (int r = 0; r < NUM_REQ; r++) mStat[r] = 0;
      end else if (ew && mStat[mOwner] < 65535) begin
        mStat[mOwner]++;
      end
`endif
      if (wr_en) begin
        wdataQ.push_back(int'(wr_data));
        wcycQ.push_back(cyc);
      end
      accMask = ew ? NUM_REQ'(1 << mOwner) : '0;
      if (mOwner < 0) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          int c;
          c = (mLast + k) % NUM_REQ;
          if (req_valid[c]) begin
            mOwner = c; mGid = c; mBeats = 0;
            break;
          end
        end
      end else if (!req_valid[mOwner]) begin
        mLast = mOwner; mOwner = -1;
      end else if (ew) begin
        mBeats++;
        if (mBeats == BURST) begin
          mLast = mOwner; mOwner = -1;
        end
      end
    end
    cyc++;
  end

  // One clock of producer behaviour; producers hold valid/data until accepted
  // except for an occasional give-up in random mode.
  task automatic applyStimulus(input logic fullV, input bit rnd);
    @(posedge clk);
    #1;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (accMask[r]) begin
        idx[r]++;
        rem[r]--;
      end
      if (rem[r] <= 0) req_valid[r] = 1'b0;
      else if (!rnd) req_valid[r] = 1'b1;
      else if (req_valid[r] && !accMask[r]) req_valid[r] = ($urandom_range(0, 7) != 0);
      else req_valid[r] = ($urandom_range(0, 3) != 0);
      req_data[r*WIDTH +: WIDTH] = wordOf(r);
    end
    fifo_full = fullV;
`ifdef FIFO_WR_ARB_STATS_EN
    stat_clr = rnd && ($urandom_range(0, 63) == 0);
`endif
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      idx[r] = 0;
      rem[r] = 0;
      req_data[r*WIDTH +: WIDTH] = wordOf(r);
    end
`ifdef FIFO_WR_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wdataQ.delete();
    wcycQ.delete();
  endtask

  task automatic checkWrite(input int k, input int d, input int c, input int base);
    if (k >= wdataQ.size()) begin
      checkOutput($sformatf("write%0d_present", k), 64'd0, 64'd1);
    end else begin
      checkOutput($sformatf("write%0d_data", k), 64'(wdataQ[k]), 64'(d));
      checkOutput($sformatf("write%0d_cycle", k), 64'(wcycQ[k] - base), 64'(c));
    end
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    fifo_full = 1'b0;
    accMask = '0;
`ifdef FIFO_WR_ARB_STATS_EN
    stat_clr = 1'b0;
`endif

    // Single requester, 6 words: burst of 4, bubble, regrant for 2.
    doReset();
    rem[0] = 6;
    applyStimulus(1'b0, 1'b0);
    base = cyc;
    repeat (10) applyStimulus(1'b0, 1'b0);
    checkOutput("s1_write_count", 64'(wdataQ.size()), 64'd6);
    for (int k = 0; k < 6; k++) checkWrite(k, 16'h1000 + k, (k < 4) ? k + 1 : k + 2, base);

    // All four valid: grants 0,1,2,3,0 with one idle cycle between bursts.
    doReset();
    rem[0] = 8; rem[1] = 4; rem[2] = 4; rem[3] = 4;
    applyStimulus(1'b0, 1'b0);
    base = cyc;
    repeat (27) applyStimulus(1'b0, 1'b0);
    checkOutput("s2_write_count", 64'(wdataQ.size()), 64'd20);
    for (int k = 0; k < 16; k++) checkWrite(k, (k / 4 + 1) * 4096 + k % 4, 1 + 5 * (k / 4) + k % 4, base);
    for (int k = 16; k < 20; k++) checkWrite(k, 16'h1004 + (k - 16), 21 + (k - 16), base);
`ifdef FIFO_WR_ARB_STATS_EN
    checkOutput("s2_stat_beats", stat_beats, 64'h0004_0004_0004_0008);
    stat_clr = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("s2_stat_cleared", stat_beats, 64'd0);
`endif

    // Requester 2 stalled by fifo_full for 3 cycles after two beats.
    doReset();
    rem[2] = 4;
    applyStimulus(1'b0, 1'b0);
    base = cyc;
    for (int t = 1; t < 12; t++) applyStimulus(t >= 3 && t <= 5, 1'b0);
    checkOutput("s3_write_count", 64'(wdataQ.size()), 64'd4);
    checkWrite(0, 16'h3000, 1, base);
    checkWrite(1, 16'h3001, 2, base);
    checkWrite(2, 16'h3002, 6, base);
    checkWrite(3, 16'h3003, 7, base);

    // Requester 1 gives up after 2 beats; waiting requester 3 goes next.
    doReset();
    rem[1] = 2; rem[3] = 4;
    applyStimulus(1'b0, 1'b0);
    base = cyc;
    for (int t = 1; t < 15; t++) begin
      if (t == 4) rem[1] += 2;
      applyStimulus(1'b0, 1'b0);
    end
    checkOutput("s4_write_count", 64'(wdataQ.size()), 64'd8);
    checkWrite(0, 16'h2000, 1, base);
    checkWrite(1, 16'h2001, 2, base);
    checkWrite(2, 16'h4000, 5, base);
    checkWrite(5, 16'h4003, 8, base);
    checkWrite(6, 16'h2002, 10, base);
    checkWrite(7, 16'h2003, 11, base);

    // Asynchronous reset in the middle of requester 0's burst.
    doReset();
    for (int r = 0; r < NUM_REQ; r++) rem[r] = 8;
    applyStimulus(1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_wr_en", 64'(wr_en), 64'd0);
    checkOutput("async_rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("async_rst_grant_active", 64'(grant_active), 64'd0);
    checkOutput("async_rst_wr_data", 64'(wr_data), 64'd0);
    checkOutput("async_rst_grant_id", 64'(grant_id), 64'd0);
    applyStimulus(1'b0, 1'b0);
    rst_n = 1'b1;
    wdataQ.delete();
    wcycQ.delete();
    base = cyc;
    repeat (8) applyStimulus(1'b0, 1'b0);
    checkWrite(0, 16'h1002, 1, base);

    // Randomized producers and FIFO backpressure.
    doReset();
    for (int r = 0; r < NUM_REQ; r++) rem[r] = 1 << 30;
    repeat (3000) applyStimulus($urandom_range(0, 4) == 0, 1'b1);
    checkOutput("random_traffic_seen", 64'(wdataQ.size() > 100), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
